if_fetch: RTL and testbench
===========================

# if_fetch

Instruction-fetch stage: owns the program counter, issues word reads to the instruction ROM over a request/acknowledge handshake, and presents `if_pc`/`if_inst` to the IF/ID pipeline register. It sits upstream of `if_id`. It honours the control module's `stall` vector, applies ID-stage branch redirects (MIPS delay-slot semantics) and exception flushes, and raises `stallreq_if` to the control module while the ROM has not delivered.

## Interface
- `RESET_PC`, default `32'h0000_0000`: first fetch address after reset.
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `stall`  in  6  control-module stall vector; only `stall[0]` (hold PC) is used.
- `branch_flag_i`  in  1  ID stage resolved a taken branch/jump.
- `branch_target_i`  in  32  target address for `branch_flag_i`.
- `flush`  in  1  exception/eret redirect; highest priority.
- `new_pc`  in  32  redirect address for `flush`.
- `rom_req`  out  1  ROM read request.
- `rom_addr`  out  32  ROM word address; held stable while `rom_req`=1 until ack.
- `rom_ack`  in  1  ROM data valid this cycle; may be asserted in the same cycle as `rom_req` (zero-wait ROM).
- `rom_rdata`  in  32  ROM read data, valid when `rom_ack`=1.
- `if_pc`  out  32  PC of the presented instruction (to `if_id`).
- `if_inst`  out  32  presented instruction; `32'h0` (nop) when none.
- `stallreq_if`  out  1  stall request to the control module.

## Operation
- Registers: `pc` (next address to fetch), `req_addr` (address on bus), `ibuf`/`ibuf_pc` (held instruction), branch pending flag plus target, state.
- States:
  - IDLE: entered only from reset. `rom_req`=0, `if_inst`=0, `if_pc`=0, `stallreq_if`=0. Next: FETCH.
  - FETCH: `rom_req`=1, `rom_addr`=`req_addr`=`pc`, `if_pc`=`req_addr`.
    - `if_inst`=`rom_rdata` if `rom_ack`, else 0.
    - `stallreq_if`=!`rom_ack`.
  - VALID: `rom_req`=0, `if_pc`=`ibuf_pc`, `if_inst`=`ibuf`, `stallreq_if`=0.
  - DRAIN: `rom_req`=1, `rom_addr`=old `req_addr`, `if_inst`=0, `stallreq_if`=1; the in-flight read is completed and its data discarded.
- Advance: an instruction advances at an edge when it is presented (FETCH with `rom_ack`, or VALID), `stall[0]`=0 and `flush`=0.
  - On advance: `pc` <= branch target if `branch_flag_i`=1 or a branch is pending (input takes precedence over pending); otherwise `pc` <= `pc`+4 (mod 2^32). Pending is cleared. State becomes FETCH.
- FETCH with `rom_ack`=1 and `stall[0]`=1: `ibuf` <= `rom_rdata`, `ibuf_pc` <= `req_addr`; state becomes VALID.
- FETCH with `rom_ack`=0: hold.
- Branch capture: at any edge with `branch_flag_i`=1 and no advance, set pending and latch `branch_target_i`. Re-capture while it stays asserted is idempotent.
- Flush (any state, overrides everything else): `pc` <= `new_pc`; pending cleared.
  - From FETCH without ack: go to DRAIN.
  - From FETCH with ack, VALID or DRAIN-with-ack: go to FETCH.
  - From DRAIN without ack: stay in DRAIN.
- DRAIN with `rom_ack`: data discarded; state becomes FETCH at the already-updated `pc`.
- No alignment check: low address bits pass through unchanged.

## Timing
- Async reset: on `rst`=0, immediately state=IDLE, `pc`=`RESET_PC`, pending=0, `ibuf`=0, `ibuf_pc`=0.
  - Output reset values: `rom_req`=0, `rom_addr`=`RESET_PC`, `if_pc`=0, `if_inst`=0, `stallreq_if`=0.
- First request is in the 2nd rising edge interval after `rst` deasserts (IDLE lasts one cycle).
- Zero-wait ROM, no stalls: one instruction per cycle, PCs consecutive +4.
- N-wait ROM: `stallreq_if`=1 for N cycles per fetch; instruction presented in the ack cycle.
- Outputs `if_pc`/`if_inst`/`rom_*`/`stallreq_if` are combinational from state, registers, and `rom_ack`/`rom_rdata` only. There is no combinational path from `stall`, `flush` or `branch_*`.
- Reset mid-request: request dropped at once; the ROM tolerates an abandoned request.

## Test plan
- Reset, zero-wait ROM returning addr as data, `RESET_PC`=0x100 -> `if_pc` 0x100,0x104,0x108 on consecutive cycles with `if_inst`=`if_pc`, `stallreq_if`=0.
- ROM ack 2 cycles late -> `stallreq_if`=1 for 2 cycles, `if_inst`=0 meanwhile; `rom_addr` stable; then instruction presented with `stallreq_if`=0.
- `stall[0]`=1 for 3 cycles when ack arrives -> state VALID, `rom_req`=0, `if_inst` held 3 cycles; release -> next fetch at +4.
- `branch_flag_i`=1, target 0x200, while fetching delay slot at 0x10C with 2-cycle ROM wait, flag dropped after 1 cycle -> 0x10C delivered, next `rom_addr`=0x200.
- `flush`=1, `new_pc`=0x180, while request at 0x110 is unacked -> DRAIN keeps `rom_addr`=0x110 until ack, data never presented, then fetch at 0x180.
- `rst` pulled low mid-FETCH -> all outputs at reset values in the same cycle, restart at `RESET_PC`.

Source files
------------

// File: rtl/if_fetch_if.sv
// ROM read bus between the fetch stage (master) and the instruction ROM (slave).
// The fetch stage raises req with a stable addr. The ROM answers with ack and rdata,
// which may arrive in the same cycle as req.
interface if_fetch_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage. It owns the PC and reads instruction words from the ROM over a
// req/ack handshake. It presents if_pc/if_inst to the IF/ID register. It honours
// stall[0], applies ID-stage branch redirects (delay-slot semantics) and exception
// flushes, and requests a pipeline stall while the ROM has not delivered.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    input  logic        flush,
    input  logic [31:0] new_pc,
    if_fetch_if.master  rom,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        stallreq_if
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] req_addr, req_addr_nxt;
    logic [31:0] ibuf, ibuf_nxt;
    logic [31:0] ibuf_pc, ibuf_pc_nxt;
    logic        br_pend, br_pend_nxt;
    logic [31:0] br_tgt, br_tgt_nxt;
    logic        presented;
    logic        advance;

    // Only the PC-hold bit of the stall vector concerns this stage.
    logic unused_stall;
    assign unused_stall = ^stall[5:1];

    // An instruction leaves the stage when it is on the outputs and nothing holds or flushes it.
    assign presented = ((state == FETCH) && rom.ack) || (state == VALID);
    assign advance   = presented && !stall[0] && !flush;

    // Control and PC state; all of it returns to known values at once on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            br_pend <= 1'b0;
            ibuf    <= 32'h0;
            ibuf_pc <= 32'h0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            br_pend <= br_pend_nxt;
            ibuf    <= ibuf_nxt;
            ibuf_pc <= ibuf_pc_nxt;
        end
    end

    // Pure data registers. They are only read once a qualifying state or flag sets them.
    always_ff @(posedge clk) begin
        req_addr <= req_addr_nxt;
        br_tgt   <= br_tgt_nxt;
    end

    // Next-state logic: a flush overrides everything; otherwise advance, buffer or hold.
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        req_addr_nxt = req_addr;
        ibuf_nxt     = ibuf;
        ibuf_pc_nxt  = ibuf_pc;
        br_pend_nxt  = br_pend;
        br_tgt_nxt   = br_tgt;

        // Remember which address is on the bus. A DRAIN that follows must keep it there.
        if (state == FETCH) begin
            req_addr_nxt = pc;
        end

        if (flush) begin
            pc_nxt      = new_pc;
            br_pend_nxt = 1'b0;
            case (state)
                FETCH:   state_nxt = rom.ack ? FETCH : DRAIN;
                DRAIN:   state_nxt = rom.ack ? FETCH : DRAIN;
                default: state_nxt = FETCH;
            endcase
        end else begin
            case (state)
                IDLE: state_nxt = FETCH;
                FETCH: begin
                    if (rom.ack && stall[0]) begin
                        ibuf_nxt    = rom.rdata;
                        ibuf_pc_nxt = pc;
                        state_nxt   = VALID;
                    end
                end
                VALID: ;
                DRAIN: if (rom.ack) state_nxt = FETCH;
                default: state_nxt = IDLE;
            endcase

            if (advance) begin
                // A branch seen this cycle wins over one captured earlier.
                if (branch_flag_i)  pc_nxt = branch_target_i;
                else if (br_pend)   pc_nxt = br_tgt;
                else                pc_nxt = pc + 32'd4;
                br_pend_nxt = 1'b0;
                state_nxt   = FETCH;
            end else if (branch_flag_i) begin
                // The delay slot is still in flight, so park the target until it leaves.
                br_pend_nxt = 1'b1;
                br_tgt_nxt  = branch_target_i;
            end
        end
    end

    // Bus and IF/ID outputs are driven only by state, registers and the ROM response.
    always_comb begin
        rom.req     = 1'b0;
        rom.addr    = pc;
        if_pc       = 32'h0;
        if_inst     = 32'h0;
        stallreq_if = 1'b0;
        case (state)
            FETCH: begin
                rom.req     = 1'b1;
                if_pc       = pc;
                if_inst     = rom.ack ? rom.rdata : 32'h0;
                stallreq_if = !rom.ack;
            end
            VALID: begin
                if_pc   = ibuf_pc;
                if_inst = ibuf;
            end
            DRAIN: begin
                rom.req     = 1'b1;
                rom.addr    = req_addr;
                if_pc       = req_addr;
                stallreq_if = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch. The bench plays the ROM itself: every vector sets
// ack/rdata and the control inputs for one cycle. Each vector also gives the outputs
// expected in that cycle.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  stall = 6'h0;
    logic        branch_flag_i = 1'b0;
    logic [31:0] branch_target_i = 32'h0;
    logic        flush = 1'b0;
    logic [31:0] new_pc = 32'h0;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        stallreq_if;

    if_fetch_if rom();

    if_fetch #(.RESET_PC(32'h0000_0100)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .flush           (flush),
        .new_pc          (new_pc),
        .rom             (rom),
        .if_pc           (if_pc),
        .if_inst         (if_inst),
        .stallreq_if     (stallreq_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        s;
        logic        bf;
        logic [31:0] bt;
        logic        fl;
        logic [31:0] np;
        logic        ack;
        logic [31:0] rd;
        logic        ereq;
        logic [31:0] eaddr;
        logic [31:0] epc;
        logic [31:0] einst;
        logic        esr;
        logic        chkpc;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(logic s, logic bf, logic [31:0] bt, logic fl, logic [31:0] np,
                                logic ack, logic [31:0] rd, logic ereq, logic [31:0] eaddr,
                                logic [31:0] epc, logic [31:0] einst, logic esr, logic chkpc);
        vec_t v;
        v.s = s; v.bf = bf; v.bt = bt; v.fl = fl; v.np = np; v.ack = ack; v.rd = rd;
        v.ereq = ereq; v.eaddr = eaddr; v.epc = epc; v.einst = einst; v.esr = esr;
        v.chkpc = chkpc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic ereq, input logic [31:0] eaddr,
                            input logic [31:0] epc, input logic [31:0] einst, input logic esr,
                            input logic chkpc);
        chk({tag, ".rom_req"},     {31'h0, rom.req},     {31'h0, ereq});
        chk({tag, ".rom_addr"},    rom.addr,             eaddr);
        if (chkpc) chk({tag, ".if_pc"}, if_pc, epc);
        chk({tag, ".if_inst"},     if_inst,              einst);
        chk({tag, ".stallreq_if"}, {31'h0, stallreq_if}, {31'h0, esr});
    endtask

    initial begin
        rom.ack   = 1'b0;
        rom.rdata = 32'h0;

        //            s  bf bt         fl np            ack rd            req addr          pc            inst          sr chkpc
        // zero-wait ROM returning address as data
        vecs.push_back(mk(0,0,32'h0,    0,32'h0,       0, 32'h0,        0, 32'h100,       32'h0,        32'h0,        0, 1)); // IDLE
        vecs.push_back(mk(0,0,32'h0,    0,32'h0,       1, 32'h100,      1, 32'h100,       32'h100,      32'h100,      0, 1));
        vecs.push_back(mk(0,0,32'h0,    0,32'h0,       1, 32'h104,      1, 32'h104,       32'h104,      32'h104,      0, 1));
        vecs.push_back(mk(0,0,32'h0,    0,32'h0,       1, 32'h108,      1, 32'h108,       32'h108,      32'h108,      0, 1));
        // two-cycle late ack at 0x10C
        vecs.push_back(mk(0,0,32'h0,    0,32'h0,       0, 32'hDEAD,     1, 32'h10C,       32'h10C,      32'h0,        1, 1));
        vecs.push_back(mk(0,0,32'h0,    0,32'h0,       0, 32'hDEAD,     1, 32'h10C,       32'h10C,      32'h0,        1, 1));
        vecs.push_back(mk(0,0,32'h0,    0,32'h0,       1, 32'hA,        1, 32'h10C,       32'h10C,      32'hA,        0, 1));
        // stall[0] held three cycles as the ack arrives at 0x110
        vecs.push_back(mk(1,0,32'h0,    0,32'h0,       1, 32'hB,        1, 32'h110,       32'h110,      32'hB,        0, 1));
        vecs.push_back(mk(1,0,32'h0,    0,32'h0,       0, 32'h0,        0, 32'h110,       32'h110,      32'hB,        0, 1));
        vecs.push_back(mk(1,0,32'h0,    0,32'h0,       0, 32'h0,        0, 32'h110,       32'h110,      32'hB,        0, 1));
        vecs.push_back(mk(0,0,32'h0,    0,32'h0,       0, 32'h0,        0, 32'h110,       32'h110,      32'hB,        0, 1));
        vecs.push_back(mk(0,0,32'h0,    0,32'h0,       1, 32'hC,        1, 32'h114,       32'h114,      32'hC,        0, 1));
        // branch to 0x200 raised for one cycle while delay slot 0x118 waits two cycles
        vecs.push_back(mk(0,1,32'h200,  0,32'h0,       0, 32'h0,        1, 32'h118,       32'h118,      32'h0,        1, 1));
        vecs.push_back(mk(0,0,32'h0,    0,32'h0,       0, 32'h0,        1, 32'h118,       32'h118,      32'h0,        1, 1));
        vecs.push_back(mk(0,0,32'h0,    0,32'h0,       1, 32'hD,        1, 32'h118,       32'h118,      32'hD,        0, 1));
        vecs.push_back(mk(0,0,32'h0,    0,32'h0,       1, 32'hE,        1, 32'h200,       32'h200,      32'hE,        0, 1));
        // branch input on the advancing edge goes straight to the PC
        vecs.push_back(mk(0,1,32'h300,  0,32'h0,       1, 32'hF,        1, 32'h204,       32'h204,      32'hF,        0, 1));
        // flush to 0x180 while 0x300 is unacked: drain, discard, refetch
        vecs.push_back(mk(0,0,32'h0,    1,32'h180,     0, 32'h0,        1, 32'h300,       32'h300,      32'h0,        1, 1));
        vecs.push_back(mk(0,0,32'h0,    0,32'h0,       0, 32'h0,        1, 32'h300,       32'h0,        32'h0,        1, 0));
        vecs.push_back(mk(0,0,32'h0,    0,32'h0,       1, 32'hBAD,      1, 32'h300,       32'h0,        32'h0,        1, 0));
        vecs.push_back(mk(0,0,32'h0,    0,32'h0,       1, 32'h11,       1, 32'h180,       32'h180,      32'h11,       0, 1));
        // flush out of VALID
        vecs.push_back(mk(1,0,32'h0,    0,32'h0,       1, 32'h12,       1, 32'h184,       32'h184,      32'h12,       0, 1));
        vecs.push_back(mk(1,0,32'h0,    1,32'h400,     0, 32'h0,        0, 32'h184,       32'h184,      32'h12,       0, 1));
        vecs.push_back(mk(0,0,32'h0,    0,32'h0,       1, 32'h13,       1, 32'h400,       32'h400,      32'h13,       0, 1));
        // flush beats a simultaneous branch, and the branch is not left pending
        vecs.push_back(mk(0,1,32'h500,  1,32'h600,     1, 32'h14,       1, 32'h404,       32'h404,      32'h14,       0, 1));
        vecs.push_back(mk(0,0,32'h0,    0,32'h0,       1, 32'h15,       1, 32'h600,       32'h600,      32'h15,       0, 1));
        // branch captured while held in VALID, applied on release
        vecs.push_back(mk(1,0,32'h0,    0,32'h0,       1, 32'h16,       1, 32'h604,       32'h604,      32'h16,       0, 1));
        vecs.push_back(mk(1,1,32'h700,  0,32'h0,       0, 32'h0,        0, 32'h604,       32'h604,      32'h16,       0, 1));
        vecs.push_back(mk(0,0,32'h0,    0,32'h0,       0, 32'h0,        0, 32'h604,       32'h604,      32'h16,       0, 1));
        vecs.push_back(mk(0,0,32'h0,    0,32'h0,       1, 32'h17,       1, 32'h700,       32'h700,      32'h17,       0, 1));
        // PC wraps modulo 2^32
        vecs.push_back(mk(0,0,32'h0,    1,32'hFFFF_FFFC,1, 32'h18,      1, 32'h704,       32'h704,      32'h18,       0, 1));
        vecs.push_back(mk(0,0,32'h0,    0,32'h0,       1, 32'h19,       1, 32'hFFFF_FFFC, 32'hFFFF_FFFC,32'h19,       0, 1));
        vecs.push_back(mk(0,0,32'h0,    0,32'h0,       1, 32'h1A,       1, 32'h0,         32'h0,        32'h1A,       0, 1));

        // reset values while rst is held low
        @(negedge clk);
        #1;
        chk_outs("reset", 1'b0, 32'h100, 32'h0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            stall           = {5'h0, vecs[i].s};
            branch_flag_i   = vecs[i].bf;
            branch_target_i = vecs[i].bt;
            flush           = vecs[i].fl;
            new_pc          = vecs[i].np;
            rom.ack         = vecs[i].ack;
            rom.rdata       = vecs[i].rd;
            #1;
            chk_outs($sformatf("v%0d", i), vecs[i].ereq, vecs[i].eaddr, vecs[i].epc,
                     vecs[i].einst, vecs[i].esr, vecs[i].chkpc);
            @(negedge clk);
        end

        // reset pulled mid-FETCH (request at 0x4 unacked): outputs drop in the same cycle
        stall = 6'h0; branch_flag_i = 1'b0; flush = 1'b0;
        rom.ack = 1'b0; rom.rdata = 32'h0;
        #1;
        chk_outs("prerst", 1'b1, 32'h4, 32'h4, 32'h0, 1'b1, 1'b1);
        #1;
        rst = 1'b0;
        #1;
        chk_outs("midrst", 1'b0, 32'h100, 32'h0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_outs("rst_idle", 1'b0, 32'h100, 32'h0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        rom.ack = 1'b1; rom.rdata = 32'h55;
        #1;
        chk_outs("restart", 1'b1, 32'h100, 32'h100, 32'h55, 1'b0, 1'b1);
        @(negedge clk);
        rom.ack = 1'b1; rom.rdata = 32'h56;
        #1;
        chk_outs("restart2", 1'b1, 32'h104, 32'h104, 32'h56, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
